helai_fifo_wr_arbiter: RTL and testbench
========================================

HELAI_FIFO_WR_ARBITER -- requirements
Module: helai_fifo_wr_arbiter

Interface
REQ-001 Parameter DSIZE, default 8: data width of each requester and of the FIFO write data.
REQ-002 Parameter CNTW, default 16: width of the per-source burst counters and the beat counter.
REQ-003 The clock is a single clock: clk, input, 1, rising edge only.
REQ-004 The reset is synchronous and active-high: rst, input, 1.
REQ-005 en, input, 1: arbitration enable; when low, no new grants are issued.
REQ-006 s0_valid / s1_valid, input, 1 each: requester beat valid.
REQ-007 s0_data / s1_data, input, DSIZE each: requester beat data.
REQ-008 s0_last / s1_last, input, 1 each: last beat of the requester's burst (line).
REQ-009 s0_ready / s1_ready, output, 1 each: beat accepted when valid and ready are both high.
REQ-010 fifo_winc, output, 1: FIFO write enable.
REQ-011 fifo_wdata, output, DSIZE: FIFO write data.
REQ-012 fifo_wsrc, output, 1: source ID of the current write (0 or 1).
REQ-013 fifo_wlast, output, 1: last flag of the current write.
REQ-014 fifo_wfull, input, 1: FIFO full.
REQ-015 fifo_awfull, input, 1: FIFO almost full.
REQ-016 busy, output, 1: a grant is held.
REQ-017 beat_cnt, output, CNTW: number of beats accepted in the current burst.
REQ-018 bursts0 / bursts1, output, CNTW each: completed-burst counters per source.

Function
REQ-019 The FSM shall have three states: IDLE, GRANT0 and GRANT1.
REQ-020 From IDLE, the FSM shall move to GRANTx on the next edge only when en=1, fifo_awfull=0 and sx_valid=1.
REQ-021 When both s0_valid and s1_valid are high in IDLE, the grant shall go to the source selected by rr_ptr.
REQ-022 In IDLE, fifo_winc, s0_ready and s1_ready shall be 0, giving a one-cycle arbitration bubble per burst.
REQ-023 In GRANTx, sx_ready shall equal ~fifo_wfull, and the other source's ready shall be 0.
REQ-024 fifo_winc shall equal sx_valid & sx_ready, combinationally, with zero latency.
REQ-025 While fifo_winc=1, fifo_wdata, fifo_wlast and fifo_wsrc shall be the granted source's data, last flag and ID, with zero latency.
REQ-026 While fifo_winc=0, fifo_wdata shall hold the granted source's data, and shall be 0 in IDLE.
REQ-027 A grant shall be held until a beat is accepted with last=1; valid low, fifo_wfull high, fifo_awfull high or en low mid-burst shall only stall the burst, never release it.
REQ-028 On acceptance of a last beat: state goes to IDLE, rr_ptr is set to the other source, burstsx increments, and beat_cnt clears to 0.
REQ-029 On any other accepted beat, beat_cnt shall increment by 1 and wrap modulo 2^CNTW; bursts0 and bursts1 shall also wrap modulo 2^CNTW.
REQ-030 A single-beat burst (valid and last in the first granted cycle) shall return the FSM to IDLE with beat_cnt remaining 0.
REQ-031 A source shall not be re-granted before the other source is considered; a lone requester is re-granted after the bubble.
REQ-032 busy shall be 1 exactly in GRANT0 and GRANT1.

Reset
REQ-033 While rst=1 at a clock edge, the state shall go to IDLE, rr_ptr to 0, and beat_cnt, bursts0 and bursts1 to 0.
REQ-034 While rst=1, fifo_winc, s0_ready and s1_ready shall be 0 combinationally.
REQ-035 A reset mid-burst shall abandon the burst without incrementing any counter.

Structure
REQ-036 The shared package helai_fifo_arb_pkg shall hold the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the source ID constants SRC0=1'b0 and SRC1=1'b1.
REQ-037 A single sub-module, helai_rr_pick2, shall take valid[1:0] and rr_ptr and produce gnt[1:0], one-hot or zero, combinationally.
REQ-038 All other logic, the FSM, the counters and the output mux, shall stay in helai_fifo_wr_arbiter.

Verification
REQ-039 Simultaneous request: after reset, s0 and s1 both valid with a 4-beat burst each (0x10..0x13 and 0x20..0x23) -> FIFO sees src0 0x10..0x13, one bubble cycle, then src1 0x20..0x23; bursts0=1 and bursts1=1.
REQ-040 Full stall: during a GRANT1 burst, fifo_wfull=1 for 3 cycles after beat 2 -> s1_ready=0 and fifo_winc=0 for those 3 cycles, no beat lost or duplicated, and beat_cnt holds 2.
REQ-041 Almost-full gate: fifo_awfull=1 in IDLE with s0_valid=1 -> no grant while it is high; grant occurs the cycle after fifo_awfull drops.
REQ-042 Lone requester: s0 alone issues 3 single-beat bursts -> each is accepted with a one-cycle bubble between; bursts0=3, and beat_cnt stays 0 throughout.
REQ-043 Reset mid-burst: rst asserted after beat 2 of an 8-beat s1 burst -> FSM returns to IDLE and bursts1=0; the next arbitration with both valid grants s0 (rr_ptr=0).
REQ-044 Counter wrap: CNTW=4 with 17 bursts from s0 -> bursts0 = 1.

Source files
------------

// File: rtl/helai_fifo_arb_pkg.sv
// Shared definitions for the two-source FIFO write arbiter.
package helai_fifo_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Source identifiers carried on fifo_wsrc.
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/helai_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// source named by i_rr_ptr wins. Output is one-hot or zero.
module helai_rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  output logic [1:0] o_gnt
);

  // Tie-break only when both sources request.
  always_comb begin
    o_gnt = i_valid;
    if (i_valid == 2'b11) begin
      o_gnt = i_rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/helai_fifo_wr_arbiter.sv
// Burst-granular arbiter merging two requester streams into one FIFO write
// port. A grant is held for a whole burst (until a last beat is accepted);
// every burst is preceded by a one-cycle arbitration bubble in IDLE.
//
// Handshake: a beat moves on a source port in any cycle where sx_valid and
// sx_ready are both high; fifo_winc is exactly that transfer, forwarded
// combinationally. Sources must hold data/last stable while valid is high
// and ready is low.
module helai_fifo_wr_arbiter
  import helai_fifo_arb_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s0_valid,
  input  logic [DSIZE-1:0] s0_data,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [DSIZE-1:0] s1_data,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic             fifo_winc,
  output logic [DSIZE-1:0] fifo_wdata,
  output logic             fifo_wsrc,
  output logic             fifo_wlast,
  input  logic             fifo_wfull,
  input  logic             fifo_awfull,
  output logic             busy,
  output logic [CNTW-1:0]  beat_cnt,
  output logic [CNTW-1:0]  bursts0,
  output logic [CNTW-1:0]  bursts1,
  output logic [1:0]       dbg_state
);

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic            r_rr_ptr;
  logic [CNTW-1:0] r_beat_cnt;
  logic [CNTW-1:0] r_bursts0;
  logic [CNTW-1:0] r_bursts1;
  logic [1:0]      w_gnt;

  helai_rr_pick2 u_pick (
    .i_valid  ({s1_valid, s0_valid}),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_gnt)
  );

  // Next-state decode and the output mux steering the granted source to the FIFO.
  always_comb begin
    w_next     = r_state;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    fifo_winc  = 1'b0;
    fifo_wdata = '0;
    fifo_wsrc  = SRC0;
    fifo_wlast = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && !fifo_awfull) begin
          if (w_gnt[0]) begin
            w_next = GRANT0;
          end else if (w_gnt[1]) begin
            w_next = GRANT1;
          end
        end
      end
      GRANT0: begin
        s0_ready   = ~fifo_wfull & ~rst;
        fifo_winc  = s0_valid & ~fifo_wfull & ~rst;
        fifo_wdata = s0_data;
        fifo_wsrc  = SRC0;
        fifo_wlast = s0_last;
        if (s0_valid && !fifo_wfull && !rst && s0_last) begin
          w_next = IDLE;
        end
      end
      GRANT1: begin
        s1_ready   = ~fifo_wfull & ~rst;
        fifo_winc  = s1_valid & ~fifo_wfull & ~rst;
        fifo_wdata = s1_data;
        fifo_wsrc  = SRC1;
        fifo_wlast = s1_last;
        if (s1_valid && !fifo_wfull && !rst && s1_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register, round-robin pointer and beat/burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
      r_bursts0  <= '0;
      r_bursts1  <= '0;
    end else begin
      r_state <= w_next;
      if (fifo_winc) begin
        if (fifo_wlast) begin
          r_beat_cnt <= '0;
          r_rr_ptr   <= ~fifo_wsrc;
          if (fifo_wsrc == SRC0) begin
            r_bursts0 <= r_bursts0 + 1'b1;
          end else begin
            r_bursts1 <= r_bursts1 + 1'b1;
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state == GRANT0) || (r_state == GRANT1);
  assign beat_cnt  = r_beat_cnt;
  assign bursts0   = r_bursts0;
  assign bursts1   = r_bursts1;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_helai_fifo_wr_arbiter.sv
// Bench for helai_fifo_wr_arbiter: per-source beat queues feed drivers, an
// expected-write queue is filled in predicted FIFO order and checked by a
// monitor on every fifo_winc; scenario tasks add targeted inline checks.
module tb_helai_fifo_wr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       s0_valid, s0_last, s0_ready;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s0_data, s1_data;
  logic       fifo_winc, fifo_wsrc, fifo_wlast;
  logic [7:0] fifo_wdata;
  logic       fifo_wfull, fifo_awfull;
  logic       busy;
  logic [15:0] beat_cnt, bursts0, bursts1;
  logic [1:0] dbg_state;

  // Second instance with narrow counters for the wrap scenario.
  logic       w2_s0_valid, w2_s0_ready, w2_s1_ready;
  logic       w2_winc, w2_wsrc, w2_wlast, w2_busy;
  logic [7:0] w2_wdata;
  logic [3:0] w2_beat_cnt, w2_bursts0, w2_bursts1;
  logic [1:0] w2_dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  logic [9:0] exp_q[$];

  helai_fifo_wr_arbiter #(.DSIZE(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata), .fifo_wsrc(fifo_wsrc),
    .fifo_wlast(fifo_wlast), .fifo_wfull(fifo_wfull), .fifo_awfull(fifo_awfull),
    .busy(busy), .beat_cnt(beat_cnt), .bursts0(bursts0), .bursts1(bursts1),
    .dbg_state(dbg_state)
  );

  helai_fifo_wr_arbiter #(.DSIZE(8), .CNTW(4)) u_wrap (
    .clk(clk), .rst(rst), .en(1'b1),
    .s0_valid(w2_s0_valid), .s0_data(8'hA5), .s0_last(1'b1), .s0_ready(w2_s0_ready),
    .s1_valid(1'b0), .s1_data(8'h00), .s1_last(1'b0), .s1_ready(w2_s1_ready),
    .fifo_winc(w2_winc), .fifo_wdata(w2_wdata), .fifo_wsrc(w2_wsrc),
    .fifo_wlast(w2_wlast), .fifo_wfull(1'b0), .fifo_awfull(1'b0),
    .busy(w2_busy), .beat_cnt(w2_beat_cnt), .bursts0(w2_bursts0), .bursts1(w2_bursts1),
    .dbg_state(w2_dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source 0 driver: present queue head, pop after an observed handshake
  initial begin : drv0
    bit acc;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
    forever begin
      @(negedge clk); acc = s0_valid && s0_ready;
      @(posedge clk); #1;
      if (acc && src0_q.size() > 0) void'(src0_q.pop_front());
      if (src0_q.size() > 0) begin
        s0_valid = 1'b1; {s0_last, s0_data} = src0_q[0];
      end else begin
        s0_valid = 1'b0; s0_last = 1'b0;
      end
    end
  end

  // Source 1 driver
  initial begin : drv1
    bit acc;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    forever begin
      @(negedge clk); acc = s1_valid && s1_ready;
      @(posedge clk); #1;
      if (acc && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src1_q.size() > 0) begin
        s1_valid = 1'b1; {s1_last, s1_data} = src1_q[0];
      end else begin
        s1_valid = 1'b0; s1_last = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every FIFO write must match the next expected entry
  initial begin : mon
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (fifo_winc) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL fifo_write unexpected: got src=%0d last=%0d data=%h, expected none",
                   fifo_wsrc, fifo_wlast, fifo_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({fifo_wsrc, fifo_wlast, fifo_wdata} !== e) begin
            err_cnt++;
            $display("FAIL fifo_write: got src=%0d last=%0d data=%h, expected src=%0d last=%0d data=%h",
                     fifo_wsrc, fifo_wlast, fifo_wdata, e[9], e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic push_beat(input bit src, input bit lst, input logic [7:0] d, input bit expect_out);
    if (src) src1_q.push_back({lst, d});
    else     src0_q.push_back({lst, d});
    if (expect_out) exp_q.push_back({src, lst, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0 && !busy) break;
    end
    vec_cnt++;
    if (k == 300) begin
      err_cnt++;
      $display("FAIL %s drain timeout: %0d writes still expected, expected 0", name, exp_q.size());
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_state", 16'(dbg_state), 16'd0);
    chk("reset_winc", 16'(fifo_winc), 16'd0);
    chk("reset_wdata", 16'(fifo_wdata), 16'd0);
    chk("reset_ready", 16'({s1_ready, s0_ready}), 16'd0);
    chk("reset_beat_cnt", beat_cnt, 16'd0);
    chk("reset_bursts0", bursts0, 16'd0);
    chk("reset_bursts1", bursts1, 16'd0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    int w[$];
    do_reset();
    for (int i = 0; i < 4; i++) push_beat(1'b0, i == 3, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < 4; i++) push_beat(1'b1, i == 3, 8'(8'h20 + i), 1'b1);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (fifo_winc) w.push_back(cyc);
      if (w.size() == 8) break;
    end
    chk("simul_writes", 16'(w.size()), 16'd8);
    if (w.size() == 8) begin
      chk("simul_burst0_len", 16'(w[3] - w[0]), 16'd3);
      chk("simul_bubble", 16'(w[4] - w[3]), 16'd2);
      chk("simul_burst1_len", 16'(w[7] - w[4]), 16'd3);
    end
    wait_drain("simul");
    chk("simul_bursts0", bursts0, 16'd1);
    chk("simul_bursts1", bursts1, 16'd1);
  endtask

  task automatic test_full_stall();
    int n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push_beat(1'b1, i == 4, 8'(8'h30 + i), 1'b1);
    for (int k = 0; k < 40 && n < 2; k++) begin
      @(negedge clk);
      if (fifo_winc) n++;
    end
    chk("stall_reach_beat2", 16'(n), 16'd2);
    @(posedge clk); #1 fifo_wfull = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_s1_ready", 16'(s1_ready), 16'd0);
      chk("stall_winc", 16'(fifo_winc), 16'd0);
      chk("stall_beat_cnt", beat_cnt, 16'd2);
      chk("stall_busy", 16'(busy), 16'd1);
    end
    @(posedge clk); #1 fifo_wfull = 1'b0;
    wait_drain("stall");
    chk("stall_bursts1", bursts1, 16'd1);
    chk("stall_beat_cnt_end", beat_cnt, 16'd0);
  endtask

  task automatic test_awfull();
    do_reset();
    fifo_awfull = 1'b1;
    push_beat(1'b0, 1'b1, 8'h5A, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("awfull_no_grant", 16'(busy), 16'd0);
      chk("awfull_no_winc", 16'(fifo_winc), 16'd0);
    end
    @(posedge clk); #1 fifo_awfull = 1'b0;
    @(negedge clk);
    chk("awfull_drop_cycle", 16'(busy), 16'd0);
    @(negedge clk);
    chk("awfull_grant_next", 16'(busy), 16'd1);
    chk("awfull_write_next", 16'(fifo_winc), 16'd1);
    wait_drain("awfull");
  endtask

  task automatic test_lone();
    int w[$];
    do_reset();
    for (int i = 0; i < 3; i++) push_beat(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("lone_beat_cnt", beat_cnt, 16'd0);
      if (fifo_winc) w.push_back(cyc);
      if (w.size() == 3) break;
    end
    chk("lone_writes", 16'(w.size()), 16'd3);
    if (w.size() == 3) begin
      chk("lone_gap1", 16'(w[1] - w[0]), 16'd2);
      chk("lone_gap2", 16'(w[2] - w[1]), 16'd2);
    end
    wait_drain("lone");
    chk("lone_bursts0", bursts0, 16'd3);
  endtask

  task automatic test_enable();
    int k;
    do_reset();
    en = 1'b0;
    push_beat(1'b0, 1'b0, 8'h61, 1'b1);
    push_beat(1'b0, 1'b1, 8'h62, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("en_low_no_grant", 16'(busy), 16'd0);
    end
    @(posedge clk); #1 en = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_winc) break;
    end
    chk("en_first_beat", 16'(k < 20), 16'd1);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    chk("en_low_holds_grant", 16'(busy), 16'd1);
    @(posedge clk); #1 en = 1'b1;
    wait_drain("enable");
    chk("en_bursts0", bursts0, 16'd1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    for (int i = 0; i < 8; i++) push_beat(1'b1, i == 7, 8'(8'h50 + i), i < 2);
    for (int k = 0; k < 40 && n < 2; k++) begin
      @(negedge clk);
      if (fifo_winc) n++;
    end
    chk("rstmid_reach_beat2", 16'(n), 16'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_low", 16'(s1_ready), 16'd0);
    chk("rstmid_winc_low", 16'(fifo_winc), 16'd0);
    @(negedge clk);
    chk("rstmid_idle", 16'(dbg_state), 16'd0);
    chk("rstmid_bursts1", bursts1, 16'd0);
    chk("rstmid_beat_cnt", beat_cnt, 16'd0);
    src1_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    push_beat(1'b0, 1'b1, 8'h60, 1'b1);
    push_beat(1'b1, 1'b1, 8'h70, 1'b1);
    wait_drain("rstmid");
    chk("rstmid_after_bursts0", bursts0, 16'd1);
    chk("rstmid_after_bursts1", bursts1, 16'd1);
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    w2_s0_valid = 1'b1;
    for (int k = 0; k < 200 && n < 17; k++) begin
      @(negedge clk);
      if (w2_winc) n++;
    end
    chk("wrap_bursts_issued", 16'(n), 16'd17);
    @(posedge clk); #1 w2_s0_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (w2_winc) n++;
    end
    chk("wrap_no_extra", 16'(n), 16'd17);
    chk("wrap_bursts0", 16'(w2_bursts0), 16'd1);
    chk("wrap_beat_cnt", 16'(w2_beat_cnt), 16'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; fifo_wfull = 1'b0; fifo_awfull = 1'b0;
    w2_s0_valid = 1'b0;
    test_reset();
    test_simultaneous();
    test_full_stall();
    test_awfull();
    test_lone();
    test_enable();
    test_reset_mid();
    test_wrap();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
